// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Operands are registered on grant, and the result is returned to the requester that issued the op.
module alu_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int SEL_WIDTH   = 4,
   parameter int ALU_LATENCY = 0
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_req0_valid,
   output logic                  o_req0_ready,
   input  logic [DATA_WIDTH-1:0] i_req0_a,
   input  logic [DATA_WIDTH-1:0] i_req0_b,
   input  logic [SEL_WIDTH-1:0]  i_req0_sel,
   output logic                  o_rsp0_valid,
   input  logic                  i_rsp0_ready,
   output logic [DATA_WIDTH-1:0] o_rsp0_data,
   output logic                  o_rsp0_zero,
   input  logic                  i_req1_valid,
   output logic                  o_req1_ready,
   input  logic [DATA_WIDTH-1:0] i_req1_a,
   input  logic [DATA_WIDTH-1:0] i_req1_b,
   input  logic [SEL_WIDTH-1:0]  i_req1_sel,
   output logic                  o_rsp1_valid,
   input  logic                  i_rsp1_ready,
   output logic [DATA_WIDTH-1:0] o_rsp1_data,
   output logic                  o_rsp1_zero,
   output logic [DATA_WIDTH-1:0] o_alu_src_a,
   output logic [DATA_WIDTH-1:0] o_alu_src_b,
   output logic [SEL_WIDTH-1:0]  o_alu_sel,
   input  logic [DATA_WIDTH-1:0] i_alu_data,
   input  logic                  i_alu_zero,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Final EXEC count: the result is sampled when the counter reaches it.
   localparam logic LAST_CNT = (ALU_LATENCY == 1);

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q, owner_d;
   logic                  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [SEL_WIDTH-1:0]  sel_q, sel_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  zero_q, zero_d;
   logic [1:0]            rsp_valid_q, rsp_valid_d;
   logic                  busy_q, busy_d;

   logic                  idle_s;
   logic                  grant_s;
   logic [1:0]            ready_s;
   logic                  req_hs_s;
   logic                  rsp_hs_s;

   // Requester 1 wins a tie only when requester 0 was served last.
   assign idle_s   = (state_q == S_IDLE);
   assign grant_s  = (i_req0_valid & i_req1_valid) ? ~last_grant_q : i_req1_valid;
   assign ready_s[0] = idle_s & i_req0_valid & ~grant_s;
   assign ready_s[1] = idle_s & i_req1_valid & grant_s;
   assign req_hs_s = |ready_s;
   assign rsp_hs_s = owner_q ? (rsp_valid_q[1] & i_rsp1_ready)
                             : (rsp_valid_q[0] & i_rsp0_ready);

   // State register and datapath capture registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         cnt_q        <= 1'b0;
         a_q          <= {DATA_WIDTH{1'b0}};
         b_q          <= {DATA_WIDTH{1'b0}};
         sel_q        <= {SEL_WIDTH{1'b0}};
         data_q       <= {DATA_WIDTH{1'b0}};
         zero_q       <= 1'b0;
         rsp_valid_q  <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sel_q        <= sel_d;
         data_q       <= data_d;
         zero_q       <= zero_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and capture logic.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      sel_d        = sel_q;
      data_d       = data_q;
      zero_d       = zero_q;
      rsp_valid_d  = rsp_valid_q;
      case (state_q)
         S_IDLE: begin
            if (req_hs_s) begin
               a_d     = grant_s ? i_req1_a   : i_req0_a;
               b_d     = grant_s ? i_req1_b   : i_req0_b;
               sel_d   = grant_s ? i_req1_sel : i_req0_sel;
               owner_d = grant_s;
               cnt_d   = 1'b0;
               state_d = S_EXEC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            if (cnt_q == LAST_CNT) begin
               data_d      = i_alu_data;
               zero_d      = i_alu_zero;
               rsp_valid_d = owner_q ? 2'b10 : 2'b01;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_hs_s) begin
               last_grant_d = owner_q;
               rsp_valid_d  = 2'b00;
               state_d      = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            rsp_valid_d = 2'b00;
            state_d     = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign o_req0_ready = ready_s[0];
   assign o_req1_ready = ready_s[1];
   assign o_rsp0_valid = rsp_valid_q[0];
   assign o_rsp1_valid = rsp_valid_q[1];
   assign o_rsp0_data  = data_q;
   assign o_rsp1_data  = data_q;
   assign o_rsp0_zero  = zero_q;
   assign o_rsp1_zero  = zero_q;
   assign o_alu_src_a  = a_q;
   assign o_alu_src_b  = b_q;
   assign o_alu_sel    = sel_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 uses a combinational ALU, instance 1 a registered ALU.
module tb_alu_arbiter;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk;
   logic          rst_n     [2];
   logic          req_valid [2][2];
   logic [DW-1:0] req_a     [2][2];
   logic [DW-1:0] req_b     [2][2];
   logic [SW-1:0] req_sel   [2][2];
   logic          rsp_ready [2][2];
   wire           req_ready [2][2];
   wire           rsp_valid [2][2];
   wire  [DW-1:0] rsp_data  [2][2];
   wire           rsp_zero  [2][2];
   wire  [DW-1:0] alu_a     [2];
   wire  [DW-1:0] alu_b     [2];
   wire  [SW-1:0] alu_sel   [2];
   wire  [DW-1:0] alu_data  [2];
   wire           alu_zero  [2];
   wire           busy      [2];

   int errors;
   int checks;
   int last_win [2];

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [SW-1:0] s);
      case (s)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      alu_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .ALU_LATENCY(g)) u_dut (
         .i_clk(clk), .i_reset_n(rst_n[g]),
         .i_req0_valid(req_valid[g][0]), .o_req0_ready(req_ready[g][0]),
         .i_req0_a(req_a[g][0]), .i_req0_b(req_b[g][0]), .i_req0_sel(req_sel[g][0]),
         .o_rsp0_valid(rsp_valid[g][0]), .i_rsp0_ready(rsp_ready[g][0]),
         .o_rsp0_data(rsp_data[g][0]), .o_rsp0_zero(rsp_zero[g][0]),
         .i_req1_valid(req_valid[g][1]), .o_req1_ready(req_ready[g][1]),
         .i_req1_a(req_a[g][1]), .i_req1_b(req_b[g][1]), .i_req1_sel(req_sel[g][1]),
         .o_rsp1_valid(rsp_valid[g][1]), .i_rsp1_ready(rsp_ready[g][1]),
         .o_rsp1_data(rsp_data[g][1]), .o_rsp1_zero(rsp_zero[g][1]),
         .o_alu_src_a(alu_a[g]), .o_alu_src_b(alu_b[g]), .o_alu_sel(alu_sel[g]),
         .i_alu_data(alu_data[g]), .i_alu_zero(alu_zero[g]), .o_busy(busy[g]));
      if (g == 0) begin : g_comb
         assign alu_data[g] = alu_f(alu_a[g], alu_b[g], alu_sel[g]);
      end else begin : g_reg
         logic [DW-1:0] res_q;
         always_ff @(posedge clk) res_q <= alu_f(alu_a[g], alu_b[g], alu_sel[g]);
         assign alu_data[g] = res_q;
      end
      assign alu_zero[g] = (alu_data[g] == 32'd0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serve one or two requests on instance d; winner order follows round-robin from last_win.
   task automatic txn(input int d, input bit v0, input bit v1,
                      input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [SW-1:0] s0,
                      input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [SW-1:0] s1,
                      input int hold, input string tag);
      bit            pend [2];
      int            w;
      int            n;
      logic [DW-1:0] ea, eb, ed;
      logic [SW-1:0] es;
      pend[0] = v0;
      pend[1] = v1;
      @(negedge clk);
      req_valid[d][0] = v0; req_a[d][0] = a0; req_b[d][0] = b0; req_sel[d][0] = s0;
      req_valid[d][1] = v1; req_a[d][1] = a1; req_b[d][1] = b1; req_sel[d][1] = s1;
      while (pend[0] || pend[1]) begin
         w  = (pend[0] && pend[1]) ? 1 - last_win[d] : (pend[1] ? 1 : 0);
         ea = req_a[d][w]; eb = req_b[d][w]; es = req_sel[d][w];
         ed = alu_f(ea, eb, es);
         #1;
         checks++;
         if (req_ready[d][w] !== 1'b1 || req_ready[d][1-w] !== 1'b0) begin
            errors++;
            $display("FAIL %s grant: ready0=%b ready1=%b, required winner %0d", tag,
                     req_ready[d][0], req_ready[d][1], w);
         end
         @(posedge clk);
         @(negedge clk);
         req_valid[d][w] = 1'b0;
         req_a[d][w]     = req_a[d][w] + 32'd6;
         req_b[d][w]     = $urandom;
         req_sel[d][w]   = 4'($urandom_range(0, 15));
         n = 1;
         while (rsp_valid[d][w] !== 1'b1 && n < 10) begin
            checks++;
            if (busy[d] !== 1'b1 || req_ready[d][0] !== 1'b0 || req_ready[d][1] !== 1'b0 ||
                alu_a[d] !== ea || alu_b[d] !== eb || alu_sel[d] !== es) begin
               errors++;
               $display("FAIL %s exec: busy=%b rdy=%b%b alu=%h/%h/%h, required busy=1 rdy=00 alu=%h/%h/%h",
                        tag, busy[d], req_ready[d][1], req_ready[d][0], alu_a[d], alu_b[d], alu_sel[d],
                        ea, eb, es);
            end
            @(negedge clk);
            n++;
         end
         checks++;
         if (rsp_valid[d][w] !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no response from requester %0d", tag, w);
            req_valid[d][0] = 1'b0;
            req_valid[d][1] = 1'b0;
            return;
         end
         checks++;
         if (n != 2 + d) begin
            errors++;
            $display("FAIL %s latency: %0d cycles, required %0d", tag, n, 2 + d);
         end
         checks++;
         if (rsp_data[d][w] !== ed || rsp_zero[d][w] !== (ed == 32'd0) || rsp_valid[d][1-w] !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp%0d: data=%h zero=%b other_valid=%b, required data=%h zero=%b other_valid=0",
                     tag, w, rsp_data[d][w], rsp_zero[d][w], rsp_valid[d][1-w], ed, (ed == 32'd0));
         end
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[d][w] !== 1'b1 || rsp_data[d][w] !== ed || busy[d] !== 1'b1 ||
                req_ready[d][0] !== 1'b0 || req_ready[d][1] !== 1'b0) begin
               errors++;
               $display("FAIL %s hold: valid=%b data=%h busy=%b rdy=%b%b, required 1/%h/1/00", tag,
                        rsp_valid[d][w], rsp_data[d][w], busy[d], req_ready[d][1], req_ready[d][0], ed);
            end
         end
         rsp_ready[d][w] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rsp_ready[d][w] = 1'b0;
         checks++;
         if (rsp_valid[d][w] !== 1'b0 || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s release: valid=%b busy=%b, required 0/0", tag, rsp_valid[d][w], busy[d]);
         end
         last_win[d] = w;
         pend[w] = 1'b0;
      end
   endtask

   task automatic pulse_reset(input int d);
      @(negedge clk);
      rst_n[d] = 1'b0;
      @(negedge clk);
      rst_n[d] = 1'b1;
      last_win[d] = 1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (busy[d] !== 1'b0 || rsp_valid[d][0] !== 1'b0 || rsp_valid[d][1] !== 1'b0 ||
             req_ready[d][0] !== 1'b0 || req_ready[d][1] !== 1'b0 || alu_a[d] !== 32'd0 ||
             alu_b[d] !== 32'd0 || alu_sel[d] !== 4'd0 || rsp_data[d][0] !== 32'd0) begin
            errors++;
            $display("FAIL reset%0d: busy=%b valid=%b%b alu=%h/%h/%h data=%h, required all zero", d,
                     busy[d], rsp_valid[d][1], rsp_valid[d][0], alu_a[d], alu_b[d], alu_sel[d],
                     rsp_data[d][0]);
         end
      end
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
   endtask

   task automatic test_single();
      rsp_ready[0][1] = 1'b1;
      txn(0, 1'b1, 1'b0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 4'd0, 0, "add_lat0");
      rsp_ready[0][1] = 1'b0;
   endtask

   task automatic test_contention();
      pulse_reset(0);
      txn(0, 1'b1, 1'b1, 32'd5, 32'd5, 4'd1, 32'h0F, 32'hF0, 4'd3, 0, "contend");
      txn(0, 1'b1, 1'b1, 32'd9, 32'd2, 4'd1, 32'd1, 32'd3, 4'd5, 0, "alternate");
   endtask

   task automatic test_backpressure();
      txn(0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'h1234, 32'h00FF, 4'd2, 4, "backpressure");
   endtask

   task automatic test_sra_lat1();
      txn(1, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'h8000_0000, 32'd1, 4'd7, 0, "sra_lat1");
   endtask

   task automatic test_reset_mid(input int d);
      @(negedge clk);
      req_valid[d][1] = 1'b1; req_a[d][1] = 32'h10; req_b[d][1] = 32'h3; req_sel[d][1] = 4'd1;
      @(posedge clk);
      @(negedge clk);
      req_valid[d][1] = 1'b0;
      checks++;
      if (busy[d] !== 1'b1) begin
         errors++;
         $display("FAIL midreset%0d busy_before: busy=%b, required 1", d, busy[d]);
      end
      rst_n[d] = 1'b0;
      #1;
      checks++;
      if (busy[d] !== 1'b0 || rsp_valid[d][0] !== 1'b0 || rsp_valid[d][1] !== 1'b0) begin
         errors++;
         $display("FAIL midreset%0d async: busy=%b valid=%b%b, required 0/00", d, busy[d],
                  rsp_valid[d][1], rsp_valid[d][0]);
      end
      @(negedge clk);
      rst_n[d] = 1'b1;
      last_win[d] = 1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy[d] !== 1'b0 || rsp_valid[d][0] !== 1'b0 || rsp_valid[d][1] !== 1'b0) begin
            errors++;
            $display("FAIL midreset%0d ghost: busy=%b valid=%b%b, required 0/00", d, busy[d],
                     rsp_valid[d][1], rsp_valid[d][0]);
         end
      end
      txn(d, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'h1234, 32'h1111, 4'd4, 1, "after_reset");
   endtask

   task automatic test_input_change(input int d);
      txn(d, 1'b1, 1'b0, 32'd3, 32'd4, 4'd0, 32'd0, 32'd0, 4'd0, 0, "input_change");
   endtask

   task automatic test_random(input int d);
      int v;
      for (int i = 0; i < 15; i++) begin
         v = $urandom_range(1, 3);
         txn(d, v[0], v[1], $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         last_win[d] = 1;
         for (int r = 0; r < 2; r++) begin
            req_valid[d][r] = 1'b0;
            req_a[d][r]     = 32'd0;
            req_b[d][r]     = 32'd0;
            req_sel[d][r]   = 4'd0;
            rsp_ready[d][r] = 1'b0;
         end
      end
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_sra_lat1();
      test_reset_mid(0);
      test_reset_mid(1);
      test_input_change(0);
      test_input_change(1);
      test_random(0);
      test_random(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters, e.g. the execute stage (requester 0) and a branch/address-compute unit (requester 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Requests are granted round-robin, and operands are registered and presented to the ALU.
- The ALU result and zero flag are captured after a parameterised latency and returned to the requester that issued the operation.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SEL_WIDTH, 4, ALU operation-select width.
- ALU_LATENCY, 0, ALU output latency in cycles: 0 = combinational, 1 = registered ALU output. Only 0 and 1 are legal.

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_req0_valid / o_req0_ready  in/out  1  requester 0 request handshake.
- i_req0_a, i_req0_b  input  DATA_WIDTH  requester 0 operands.
- i_req0_sel  input  SEL_WIDTH  requester 0 operation.
- o_rsp0_valid / i_rsp0_ready  out/in  1  requester 0 response handshake.
- o_rsp0_data  output  DATA_WIDTH  requester 0 result.
- o_rsp0_zero  output  1  requester 0 zero flag.
- i_req1_*, o_req1_ready, o_rsp1_*, i_rsp1_ready  same as requester 0, for requester 1.
- o_alu_src_a, o_alu_src_b  output  DATA_WIDTH  shared ALU operands.
- o_alu_sel  output  SEL_WIDTH  shared ALU operation select.
- i_alu_data  input  DATA_WIDTH  ALU result.
- i_alu_zero  input  1  ALU zero flag.
- o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on i_reset_n. Reset forces:
  - state = IDLE, last_grant = 1, so requester 0 wins the first contest;
  - operand, sel and result registers = 0;
  - every valid/ready output = 0, o_busy = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. Only one requester valid → that one. Both valid → the requester not equal to last_grant.
  - o_reqN_ready = 1 only for the granted requester, only in IDLE; at most one ready is high in any cycle.
  - Handshake (valid & ready) at cycle T captures a, b, sel and the owner ID. The FSM enters EXEC at T+1.
- EXEC:
  - Lasts ALU_LATENCY+1 cycles, tracked by an internal counter.
  - o_alu_* are driven from the captured registers.
  - On the last EXEC cycle, i_alu_data and i_alu_zero are registered into the result registers. The FSM then enters RESP at T+2+ALU_LATENCY.
- RESP:
  - o_rspN_valid = 1 for the owner only; data and zero are held stable until i_rspN_ready.
  - On the response handshake: last_grant <= owner, FSM returns to IDLE the next cycle, and o_rsp valid drops.
  - No request is accepted in EXEC or RESP; both req_ready outputs stay 0. Throughput is one op per 3+ALU_LATENCY cycles minimum.
- Outputs between transactions:
  - o_alu_* hold the last captured operands; they are not zeroed between ops.
  - o_rspN_data / o_rspN_zero hold the last result; they are only meaningful while valid.
- sel values outside the ALU's defined range are forwarded unmodified; no checking is done.
- Request inputs are sampled only on handshake. Changes to a, b or sel after the handshake do not affect the in-flight op.
- Requesters keep valid asserted until ready. If a requester deasserts valid before ready, its request is dropped with no side effects.
- Asserting i_rspN_ready while that rsp_valid is low has no effect.
- Reset mid-EXEC or mid-RESP: the in-flight transaction is discarded, no response is produced, and all outputs return to reset values immediately (asynchronous).
- Zero flag is passed through from i_alu_zero; no recomputation.

Test Plan:
- ALU_LATENCY=0:
  - req0 a=5, b=7, sel=0000 handshake at T → o_rsp0_valid rises at T+2 with data=12, zero=0.
  - o_req1_ready stays 0 throughout.
- Contention after reset:
  - req0 SUB 5-5 and req1 OR 0x0F|0xF0 both valid at T → req0 granted first; rsp0 data=0, zero=1.
  - req1 is then granted in the first IDLE cycle after the rsp0 handshake; rsp1 data=0xFF.
  - Next simultaneous request pair → req0 granted again, confirming alternation.
- Backpressure:
  - i_rsp1_ready held 0 for 4 cycles during RESP → o_rsp1_valid/data stay stable.
  - o_req0_ready stays 0 and o_busy stays 1; the response completes on the first ready cycle.
- ALU_LATENCY=1 with a registered ALU model:
  - req1 SRA a=0x8000_0000, b=1, sel=0111 → rsp1 valid at T+3 with data=0xC000_0000.
  - ALU operands stay stable across both EXEC cycles.
- Reset mid-op:
  - Assert i_reset_n=0 during EXEC → o_busy=0, all valids=0 immediately, no response produced.
  - After release, req1-only request → granted, and the correct result is returned.
- Input change after handshake:
  - Change i_req0_a from 3 to 9 one cycle after an ADD 3+4 handshake → response data=7.
